// File: rtl/rotor_reverse.sv
// rotor_reverse: return-path rotor stage (left-to-right inverse wiring) behind a one-deep valid/ready output register.
// Define ROTOR_REVERSE_NOTCH_EN to build the turnover (notch) pulse; otherwise notch is tied low.
module rotor_reverse #(
  parameter int NOTCH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_left,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_right,
  output logic       out_err,
  input  logic       load,
  input  logic [4:0] load_val,
  input  logic       step,
  output logic [4:0] pos,
  output logic       notch
);

  if (NOTCH < 0 || NOTCH > 25) begin : g_notchRangeCheck
    $error("rotor_reverse: NOTCH must lie in 0..25");
  end

  logic       r_valid;
  logic [4:0] r_right;
  logic       r_err;
  logic [4:0] r_pos;

  logic [5:0] w_sum;
  logic [5:0] w_contact;
  logic [5:0] w_inv;
  logic [4:0] w_exit;
  logic       w_illegal;
  logic       w_xfer;
  logic       w_loadOk;

  function automatic logic [5:0] invWire(input logic [5:0] c);
    logic [5:0] r;
    case (c)
      6'd0:    r = 6'd20;
      6'd1:    r = 6'd22;
      6'd2:    r = 6'd24;
      6'd3:    r = 6'd6;
      6'd4:    r = 6'd0;
      6'd5:    r = 6'd3;
      6'd6:    r = 6'd5;
      6'd7:    r = 6'd15;
      6'd8:    r = 6'd21;
      6'd9:    r = 6'd25;
      6'd10:   r = 6'd1;
      6'd11:   r = 6'd4;
      6'd12:   r = 6'd2;
      6'd13:   r = 6'd10;
      6'd14:   r = 6'd12;
      6'd15:   r = 6'd19;
      6'd16:   r = 6'd7;
      6'd17:   r = 6'd23;
      6'd18:   r = 6'd18;
      6'd19:   r = 6'd11;
      6'd20:   r = 6'd17;
      6'd21:   r = 6'd8;
      6'd22:   r = 6'd13;
      6'd23:   r = 6'd16;
      6'd24:   r = 6'd14;
      6'd25:   r = 6'd9;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  // Sum is kept 6 bits wide so in_left+pos (up to 50) reduces mod 26 without a 5-bit wrap.
  always_comb begin
    w_sum     = {1'b0, in_left} + {1'b0, r_pos};
    w_contact = (w_sum >= 6'd26) ? (w_sum - 6'd26) : w_sum;
    w_inv     = invWire(w_contact);
    w_exit    = 5'((w_inv >= {1'b0, r_pos}) ? (w_inv - {1'b0, r_pos})
                                           : (w_inv + 6'd26 - {1'b0, r_pos}));
    w_illegal = (in_left > 5'd25);
    w_loadOk  = load && (load_val <= 5'd25);
  end

  assign in_ready = !r_valid || out_ready;
  assign w_xfer   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_right <= 5'd0;
      r_err   <= 1'b0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_right <= w_illegal ? 5'd0 : w_exit;
      r_err   <= w_illegal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // An illegal load value suppresses the whole position update, including a coincident step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= 5'd0;
    end else if (load) begin
      if (w_loadOk) begin
        r_pos <= load_val;
      end
    end else if (step) begin
      r_pos <= (r_pos == 5'd25) ? 5'd0 : (r_pos + 5'd1);
    end
  end

`ifdef ROTOR_REVERSE_NOTCH_EN
  logic r_notch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_notch <= 1'b0;
    end else begin
      r_notch <= step && !load && (r_pos == 5'(NOTCH));
    end
  end

  assign notch = r_notch;
`else
  assign notch = 1'b0;
`endif

  assign out_valid = r_valid;
  assign out_right = r_right;
  assign out_err   = r_err;
  assign pos       = r_pos;

endmodule

// File: tb/tb_rotor_reverse.sv
// Scoreboarded bench for rotor_reverse: driver pushes model results, a monitor pops them on each consumed output.
module tb_rotor_reverse;

  localparam int NOTCH_TB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_left = 5'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] out_right;
  logic       out_err;
  logic       load = 1'b0;
  logic [4:0] load_val = 5'd0;
  logic       step = 1'b0;
  logic [4:0] pos;
  logic       notch;

  typedef struct {
    int right;
    int err;
  } exp_t;

  exp_t sbQ[$];
  int   nVec = 0;
  int   nMis = 0;
  int   inv[26] = '{20,22,24,6,0,3,5,15,21,25,1,4,2,10,12,19,7,23,18,11,17,8,13,16,14,9};

  int   mPos = 0;
  int   mValid = 0;
  int   mNotch = 0;

  rotor_reverse #(.NOTCH(NOTCH_TB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left),
    .out_valid(out_valid), .out_ready(out_ready), .out_right(out_right), .out_err(out_err),
    .load(load), .load_val(load_val), .step(step),
    .pos(pos), .notch(notch)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: act=timeout req=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int req);
    nVec++;
    if (act != req) begin
      nMis++;
      $display("[TB] FAIL %s: act=%0d req=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Character result from the rotor's rules, computed with plain integer modulo arithmetic.
  function automatic exp_t modelChar(input int l, input int p);
    exp_t e;
    if (l > 25) begin
      e.right = 0;
      e.err   = 1;
    end else begin
      e.right = (inv[(l + p) % 26] - p + 26) % 26;
      e.err   = 0;
    end
    return e;
  endfunction

  // Called at posedge+1; checks handshake/position at the negedge, then advances the model across the next edge.
  task automatic applyStimulus(input bit v, input int l, input bit ld, input int lv, input bit st, input bit ordy);
    bit xfer;
    in_valid  = v;
    in_left   = 5'(l);
    load      = ld;
    load_val  = 5'(lv);
    step      = st;
    out_ready = ordy;
    @(negedge clk);
    checkOutput("in_ready", int'(in_ready), (mValid == 0 || ordy) ? 1 : 0);
    checkOutput("out_valid", int'(out_valid), mValid);
    checkOutput("pos", int'(pos), mPos);
    checkOutput("notch", int'(notch), mNotch);
    xfer = v && (mValid == 0 || ordy);
    if (xfer) sbQ.push_back(modelChar(l, mPos));
    if (xfer) mValid = 1;
    else if (ordy) mValid = 0;
`ifdef ROTOR_REVERSE_NOTCH_EN
    mNotch = (st && !ld && mPos == NOTCH_TB) ? 1 : 0;
`else
    mNotch = 0;
`endif
    if (ld) begin
      if (lv <= 25) mPos = lv;
    end else if (st) begin
      mPos = (mPos + 1) % 26;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("out_right", int'(out_right), e.right);
        checkOutput("out_err", int'(out_err), e.err);
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_pos", int'(pos), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_right", int'(out_right), 0);
    checkOutput("rst_out_err", int'(out_err), 0);
    checkOutput("rst_notch", int'(notch), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(1, 4, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1, 0, 1);
    applyStimulus(1, 3, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 25, 0, 1);
    applyStimulus(1, 5, 0, 0, 0, 1);

    applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 1, 16, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 16, 0, 1);
    applyStimulus(0, 0, 1, 16, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    applyStimulus(0, 0, 1, 0, 0, 1);
    applyStimulus(1, 7, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 9, 0, 0, 0, 0);
      checkOutput("held_out_right", int'(out_right), sbQ[0].right);
    end
    for (int i = 0; i < 26; i++) applyStimulus(1, i, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    applyStimulus(1, 30, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 28, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 31),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 31),
                    $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
    end

    applyStimulus(0, 0, 1, 12, 0, 1);
    applyStimulus(1, 6, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_pos", int'(pos), 0);
    checkOutput("async_out_valid", int'(out_valid), 0);
    checkOutput("async_out_right", int'(out_right), 0);
    checkOutput("async_out_err", int'(out_err), 0);
    checkOutput("async_notch", int'(notch), 0);
    mPos = 0;
    mValid = 0;
    mNotch = 0;
    sbQ.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1, 4, 0, 0, 0, 1);

    repeat (3) applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("scoreboard_empty", sbQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
